up_counter: RTL and testbench

UP_COUNTER -- requirements
Module: up_counter

---
 rtl/up_counter_if.sv | 23 ++
 rtl/up_counter.sv | 32 +++
 tb/tb_up_counter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/up_counter_if.sv
// Bundles the enable, terminal value and count of an up_counter so that a
// controller and the counter can be wired together as one connection.
interface up_counter_if #(
    parameter int unsigned WIDTH = 2
);
    logic             condition_check;
    logic [WIDTH-1:0] min_index;
    logic [WIDTH-1:0] count;

    // The controller drives the enable and terminal value and observes the count.
    modport master (
        output condition_check,
        output min_index,
        input  count
    );

    // The counter receives the enable and terminal value and drives the count.
    modport slave (
        input  condition_check,
        input  min_index,
        output count
    );
endinterface

// File: rtl/up_counter.sv
// Enabled up-counter that saturates at a terminal value sampled every cycle.
// Reset is synchronous; a lowered terminal value freezes the count.
module up_counter #(
    parameter int unsigned WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             condition_check,
    input  logic [WIDTH-1:0] min_index,
    output logic [WIDTH-1:0] count
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Advance only while enabled and strictly below the terminal value, so no wrap.
    always_comb begin
        count_d = count_q;
        if (condition_check && (count_q < min_index)) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
endmodule

// File: tb/tb_up_counter.sv
// Directed bench for up_counter: basic count, enable gating, terminal changes,
// synchronous reset behaviour, with hand-computed expected counts.
`timescale 1ns/1ps
module tb_up_counter;
    localparam int unsigned WIDTH = 2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    up_counter_if #(.WIDTH(WIDTH)) bus ();

    up_counter #(.WIDTH(WIDTH)) dut (
        .clk             (clk),
        .reset           (reset),
        .condition_check (bus.condition_check),
        .min_index       (bus.min_index),
        .count           (bus.count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Advance to 1ns after the next rising edge, where outputs are sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("reset", 8'(bus.count), 8'd0);
    endtask

    initial begin
        logic [7:0] basic_exp [10];
        n_checks = 0;
        n_errors = 0;
        reset = 1'b0;
        bus.condition_check = 1'b0;
        bus.min_index = '0;

        // Basic count with absolute timing: edges at 5, 15, 25, ...
        #2;
        reset = 1'b1;
        bus.condition_check = 1'b1;
        bus.min_index = 2'b11;
        @(posedge clk);
        #1;
        check("basic_t5", 8'(bus.count), 8'd0);
        #1;
        reset = 1'b0;
        basic_exp = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3, 8'd3};
        for (int i = 0; i < 10; i++) begin
            step();
            check($sformatf("basic_e%0d", i), 8'(bus.count), basic_exp[i]);
        end

        // Enable gating: freeze at 1 for three edges, then resume to 2.
        do_reset();
        bus.min_index = 2'd3;
        bus.condition_check = 1'b1;
        step();
        check("gate_start", 8'(bus.count), 8'd1);
        bus.condition_check = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("gate_hold%0d", i), 8'(bus.count), 8'd1);
        end
        bus.condition_check = 1'b1;
        step();
        check("gate_resume", 8'(bus.count), 8'd2);

        // Lowered terminal: count 2 with terminal 1 holds, no decrement or wrap.
        bus.min_index = 2'd1;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("lowered%0d", i), 8'(bus.count), 8'd2);
        end

        // Zero terminal keeps count at zero.
        do_reset();
        bus.min_index = 2'd0;
        bus.condition_check = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("zero%0d", i), 8'(bus.count), 8'd0);
        end

        // Raised terminal: saturate at 1, then raise to 3 and resume.
        bus.min_index = 2'd1;
        step();
        check("raise_sat1", 8'(bus.count), 8'd1);
        step();
        check("raise_hold1", 8'(bus.count), 8'd1);
        bus.min_index = 2'd3;
        step();
        check("raise_2", 8'(bus.count), 8'd2);
        step();
        check("raise_3", 8'(bus.count), 8'd3);

        // Reset mid-count: 2 -> reset -> 0, then 1, 2.
        do_reset();
        step();
        step();
        check("mid_pre", 8'(bus.count), 8'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_reset", 8'(bus.count), 8'd0);
        step();
        check("mid_res1", 8'(bus.count), 8'd1);
        step();
        check("mid_res2", 8'(bus.count), 8'd2);

        // Reset pulse entirely between edges has no effect; the next edge counts.
        #2;
        reset = 1'b1;
        #2;
        check("glitch_mid", 8'(bus.count), 8'd2);
        reset = 1'b0;
        step();
        check("glitch_edge", 8'(bus.count), 8'd3);

        // Reset while saturated overrides enable and terminal.
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("sat_reset", 8'(bus.count), 8'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
